// File: rtl/adsr_envelope_amp_if.sv
`timescale 1ns/1ps
// Gate, sample and envelope-parameter bundle for the ADSR amplitude stage.
interface adsr_envelope_amp_if;
   logic       gate_in;
   logic [7:0] wave_in;
   logic [7:0] attack_rate;
   logic [7:0] decay_rate;
   logic [7:0] sustain_level;
   logic [7:0] release_rate;
   logic [7:0] wave_out;
   logic [7:0] env_level;
   logic [2:0] env_state;
   logic       busy;

   // Source of gate/sample/parameters, consumer of the scaled voice.
   modport master (
      output gate_in, wave_in, attack_rate, decay_rate, sustain_level, release_rate,
      input  wave_out, env_level, env_state, busy
   );

   // The envelope amplifier itself.
   modport slave (
      input  gate_in, wave_in, attack_rate, decay_rate, sustain_level, release_rate,
      output wave_out, env_level, env_state, busy
   );
endinterface

// File: rtl/adsr_envelope_amp.sv
`timescale 1ns/1ps
// ADSR envelope generator plus registered 8x9 amplitude multiply.
// Level steps occur only on prescaler ticks; gate edges act on any cycle.
module adsr_envelope_amp #(
   parameter int unsigned TICK_DIV = 256
) (
   input logic              clk,
   input logic              reset,
   adsr_envelope_amp_if.slave bus
);

   localparam int unsigned   CW        = $clog2(TICK_DIV);
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    level_q, level_d;
   logic [7:0]    wave_q,  wave_d;
   logic [CW-1:0] tick_cnt_q, tick_cnt_d;
   logic          gate_q;
   logic          tick;
   logic          rise;
   logic [8:0]    atk_inc;
   logic [8:0]    atk_sum;
   logic [8:0]    dec_floor;

   assign tick = (tick_cnt_q == TICK_LAST);
   assign rise = bus.gate_in & ~gate_q;

   // Prescaler wrap and scaled-sample computation from the registered level.
   always_comb begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      wave_d     = 8'(({9'd0, bus.wave_in} * ({9'd0, level_q} + 17'd1)) >> 8);
   end

   // Envelope next state/level: rise beats gate-low, gate-low beats tick step.
   always_comb begin
      state_d   = state_q;
      level_d   = level_q;
      atk_inc   = (bus.attack_rate == 8'd0) ? 9'd255 : {1'b0, bus.attack_rate};
      atk_sum   = {1'b0, level_q} + atk_inc;
      // level - decay <= sustain rewritten as level <= sustain + decay to avoid underflow
      dec_floor = {1'b0, bus.sustain_level} + {1'b0, bus.decay_rate};

      if (rise) begin
         state_d = S_ATTACK;
      end else if (!bus.gate_in &&
                   (state_q == S_ATTACK || state_q == S_DECAY || state_q == S_SUSTAIN)) begin
         state_d = S_RELEASE;
      end else if (tick) begin
         case (state_q)
            S_ATTACK: begin
               if (atk_sum >= 9'd255) begin
                  level_d = 8'd255;
                  state_d = S_DECAY;
               end else begin
                  level_d = atk_sum[7:0];
               end
            end
            S_DECAY: begin
               if (bus.decay_rate == 8'd0 || {1'b0, level_q} <= dec_floor) begin
                  level_d = bus.sustain_level;
                  state_d = S_SUSTAIN;
               end else begin
                  level_d = level_q - bus.decay_rate;
               end
            end
            S_SUSTAIN: begin
               level_d = bus.sustain_level;
            end
            S_RELEASE: begin
               if (bus.release_rate == 8'd0 || level_q <= bus.release_rate) begin
                  level_d = '0;
                  state_d = S_IDLE;
               end else begin
                  level_d = level_q - bus.release_rate;
               end
            end
            default: begin
               level_d = '0;
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // All state registers with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         level_q    <= '0;
         wave_q     <= '0;
         tick_cnt_q <= '0;
         gate_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         wave_q     <= wave_d;
         tick_cnt_q <= tick_cnt_d;
         gate_q     <= bus.gate_in;
      end
   end

   assign bus.wave_out  = wave_q;
   assign bus.env_level = level_q;
   assign bus.env_state = state_q;
   assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_adsr_envelope_amp.sv
`timescale 1ns/1ps
// Self-checking bench for adsr_envelope_amp (TICK_DIV=4): table of envelope
// checkpoints, hand-written corner sequences, then randomized run against a model.
module tb_adsr_envelope_amp;

   localparam int TD = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   adsr_envelope_amp_if bus ();

   adsr_envelope_amp #(.TICK_DIV(TD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: envelope as plain integers, updated once per clock.
   int m_state = 0;
   int m_level = 0;
   int m_cnt   = 0;
   int m_wave  = 0;
   bit m_gprev = 1'b0;
   bit m_tick  = 1'b0;

   typedef struct {
      int cycles;
      bit gate;
      int atk;
      int dec;
      int sus;
      int rel;
      int exp_state;
      int exp_level;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int g;
      int inc;
      g = int'(bus.gate_in);
      if (!reset) begin
         m_state = 0; m_level = 0; m_cnt = 0; m_wave = 0; m_gprev = 1'b0; m_tick = 1'b0;
         return;
      end
      m_tick = (m_cnt == TD - 1);
      m_cnt  = m_tick ? 0 : m_cnt + 1;
      m_wave = (int'(bus.wave_in) * (m_level + 1)) / 256;
      if (g == 1 && !m_gprev) begin
         m_state = 1;
      end else if (g == 0 && m_state >= 1 && m_state <= 3) begin
         m_state = 4;
      end else if (m_tick) begin
         if (m_state == 1) begin
            inc = (bus.attack_rate == 0) ? 255 : int'(bus.attack_rate);
            m_level = m_level + inc;
            if (m_level >= 255) begin m_level = 255; m_state = 2; end
         end else if (m_state == 2) begin
            if (bus.decay_rate == 0 || m_level - int'(bus.decay_rate) <= int'(bus.sustain_level)) begin
               m_level = int'(bus.sustain_level); m_state = 3;
            end else begin
               m_level = m_level - int'(bus.decay_rate);
            end
         end else if (m_state == 3) begin
            m_level = int'(bus.sustain_level);
         end else if (m_state == 4) begin
            if (bus.release_rate == 0 || m_level <= int'(bus.release_rate)) begin
               m_level = 0; m_state = 0;
            end else begin
               m_level = m_level - int'(bus.release_rate);
            end
         end else begin
            m_level = 0;
         end
      end
      m_gprev = bus.gate_in;
   endtask

   task automatic clk1();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".state"}, int'(bus.env_state), m_state);
      chk({tag, ".level"}, int'(bus.env_level), m_level);
      chk({tag, ".busy"},  int'(bus.busy),      (m_state != 0) ? 1 : 0);
      chk({tag, ".wave"},  int'(bus.wave_out),  m_wave);
   endtask

   task automatic run_to_tick(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < TD; i++) begin
         clk1();
         chk_model(tag);
         if (m_tick) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, ".tick_seen"}, int'(seen), 1);
   endtask

   task automatic align_tick();
      for (int i = 0; i < TD; i++) begin
         if (m_cnt == TD - 1) break;
         clk1();
      end
   endtask

   task automatic set_rates(input int a, input int d, input int s, input int r);
      bus.attack_rate   = 8'(a);
      bus.decay_rate    = 8'(d);
      bus.sustain_level = 8'(s);
      bus.release_rate  = 8'(r);
   endtask

   initial begin
      tbl[0]  = '{1, 1'b1, 100, 50, 128, 60, 1, 0};
      tbl[1]  = '{3, 1'b1, 100, 50, 128, 60, 1, 100};
      tbl[2]  = '{4, 1'b1, 100, 50, 128, 60, 1, 200};
      tbl[3]  = '{4, 1'b1, 100, 50, 128, 60, 2, 255};
      tbl[4]  = '{4, 1'b1, 100, 50, 128, 60, 2, 205};
      tbl[5]  = '{4, 1'b1, 100, 50, 128, 60, 2, 155};
      tbl[6]  = '{4, 1'b1, 100, 50, 128, 60, 3, 128};
      tbl[7]  = '{1, 1'b0, 100, 50, 128, 60, 4, 128};
      tbl[8]  = '{3, 1'b0, 100, 50, 128, 60, 4, 68};
      tbl[9]  = '{4, 1'b0, 100, 50, 128, 60, 4, 8};
      tbl[10] = '{4, 1'b0, 100, 50, 128, 60, 0, 0};

      // Reset held with gate high and a live sample
      reset       = 1'b0;
      bus.gate_in = 1'b1;
      bus.wave_in = 8'd200;
      set_rates(100, 50, 128, 60);
      for (int i = 0; i < 3; i++) begin
         clk1();
         chk("rst.state", int'(bus.env_state), 0);
         chk("rst.level", int'(bus.env_level), 0);
         chk("rst.wave",  int'(bus.wave_out),  0);
         chk("rst.busy",  int'(bus.busy),      0);
      end
      reset = 1'b1;

      // Attack/decay/sustain/release checkpoints
      for (int v = 0; v < 11; v++) begin
         bus.gate_in = tbl[v].gate;
         set_rates(tbl[v].atk, tbl[v].dec, tbl[v].sus, tbl[v].rel);
         for (int c = 0; c < tbl[v].cycles; c++) begin
            clk1();
            chk_model("tbl.model");
         end
         chk("tbl.state", int'(bus.env_state), tbl[v].exp_state);
         chk("tbl.level", int'(bus.env_level), tbl[v].exp_level);
         chk("tbl.busy",  int'(bus.busy),      (tbl[v].exp_state != 0) ? 1 : 0);
      end

      // Retrigger from RELEASE at level 150
      set_rates(0, 0, 150, 60);
      bus.gate_in = 1'b1;
      clk1();
      chk("rt.attack", int'(bus.env_state), 1);
      run_to_tick("rt.a0");
      chk("rt.a0lvl", int'(bus.env_level), 255);
      run_to_tick("rt.d0");
      chk("rt.sus", int'(bus.env_state), 3);
      chk("rt.suslvl", int'(bus.env_level), 150);
      bus.gate_in = 1'b0;
      clk1();
      chk("rt.rel", int'(bus.env_state), 4);
      chk("rt.rellvl", int'(bus.env_level), 150);
      bus.gate_in = 1'b1;
      bus.attack_rate = 8'd100;
      clk1();
      chk("rt.retrig", int'(bus.env_state), 1);
      chk("rt.retriglvl", int'(bus.env_level), 150);
      run_to_tick("rt.t1");
      chk("rt.250", int'(bus.env_level), 250);
      run_to_tick("rt.t2");
      chk("rt.255", int'(bus.env_level), 255);
      chk("rt.decay", int'(bus.env_state), 2);

      // Output scaling and one-clock latency
      bus.sustain_level = 8'd255;
      run_to_tick("sc.hold");
      chk("sc.lvl255", int'(bus.env_level), 255);
      bus.wave_in = 8'd255;
      clk1();
      chk("sc.w255", int'(bus.wave_out), 255);
      bus.wave_in = 8'd37;
      #1;
      chk("sc.latency", int'(bus.wave_out), 255);
      clk1();
      chk("sc.w37", int'(bus.wave_out), 37);
      bus.sustain_level = 8'd127;
      run_to_tick("sc.track");
      chk("sc.lvl127", int'(bus.env_level), 127);
      bus.wave_in = 8'd200;
      clk1();
      chk("sc.w100", int'(bus.wave_out), 100);
      bus.gate_in = 1'b0;
      bus.release_rate = 8'd0;
      clk1();
      run_to_tick("sc.rel0");
      chk("sc.idle", int'(bus.env_state), 0);
      chk("sc.lvl0", int'(bus.env_level), 0);
      clk1();
      chk("sc.w0", int'(bus.wave_out), 0);
      chk("sc.busy0", int'(bus.busy), 0);

      // Rise coincident with tick takes no step
      set_rates(0, 0, 100, 10);
      align_tick();
      bus.gate_in = 1'b1;
      clk1();
      chk("rtk.state", int'(bus.env_state), 1);
      chk("rtk.level", int'(bus.env_level), 0);
      run_to_tick("rtk.a");
      chk("rtk.255", int'(bus.env_level), 255);
      run_to_tick("rtk.d");
      chk("rtk.sus", int'(bus.env_level), 100);
      // Gate falling on a tick also takes no step
      align_tick();
      bus.gate_in = 1'b0;
      clk1();
      chk("gtk.state", int'(bus.env_state), 4);
      chk("gtk.level", int'(bus.env_level), 100);

      // Randomized run against the model
      for (int i = 0; i < 4000; i++) begin
         bus.wave_in = 8'($urandom);
         if ($urandom_range(15) == 0) bus.gate_in = ~bus.gate_in;
         if ($urandom_range(63) == 0) begin
            set_rates(($urandom_range(3) == 0) ? 0 : $urandom_range(255),
                      ($urandom_range(3) == 0) ? 0 : $urandom_range(255),
                      $urandom_range(255),
                      ($urandom_range(3) == 0) ? 0 : $urandom_range(120));
         end
         reset = ($urandom_range(499) == 0) ? 1'b0 : 1'b1;
         clk1();
         chk_model("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
